// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: host byte-protocol master that turns UART commands into 32-bit bus reads/writes and replies.
module uart_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 12000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_avail,
  input  logic        rx_error,
  output logic        rx_ack,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_busy,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  output logic        bus_rstrb,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rbusy,
  input  logic        bus_wbusy,
  output logic        active
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS_WR, BUS_RD, TX_LOAD, TX_WAIT} state_t;
  state_t state, state_n;
  logic [7:0] op;
  logic [31:0] addr, wdata, reply, tmr;
  logic [1:0] cnt;
  logic first, ack_d, err, take, rx_state, fields, timeout;
  assign rx_state = state == IDLE || state == ADDR || state == DATA;
  assign fields = state == ADDR || state == DATA;
  // the uart drops rx_avail/rx_error only the cycle after our ack, so that cycle is ignored
  assign err = !ack_d && rx_error;
  assign take = !ack_d && !rx_error && rx_avail && rx_state;
  assign timeout = TIMEOUT_CYCLES != 0 && fields && !take && tmr == 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (take) state_n = (rx_data == 8'h57 || rx_data == 8'h52) ? ADDR : TX_LOAD;
      ADDR:    state_n = (take && cnt == 2'd3) ? (op == 8'h57 ? DATA : BUS_RD) : timeout ? IDLE : ADDR;
      DATA:    state_n = (take && cnt == 2'd3) ? BUS_WR : timeout ? IDLE : DATA;
      BUS_WR:  if (!first && !bus_wbusy) state_n = TX_LOAD;
      BUS_RD:  if (!first && !bus_rbusy) state_n = TX_LOAD;
      TX_LOAD: if (!tx_busy) state_n = TX_WAIT;
      TX_WAIT: if (!first && !tx_busy) state_n = cnt == 2'd0 ? IDLE : TX_LOAD;
      default: state_n = IDLE;
    endcase
    if (err) state_n = IDLE;
  end
  // first marks the opening cycle of every state: bus strobes fire then, TX_WAIT skips it
  always_ff @(posedge clk)
    if (reset) begin
      op <= '0;
      addr <= '0;
      wdata <= '0;
      reply <= '0;
      tmr <= '0;
      cnt <= '0;
      first <= 1'b0;
      ack_d <= 1'b0;
    end else begin
      ack_d <= rx_ack;
      first <= state_n != state;
      tmr <= (take || !fields) ? '0 : tmr + 32'd1;
      if (take)
        case (state)
          IDLE: begin
            op <= rx_data;
            cnt <= '0;
            reply <= {rx_data == 8'h50 ? 8'h4B : 8'h3F, 24'h0};
          end
          ADDR: begin
            addr <= {addr[23:0], rx_data};
            cnt <= cnt + 2'd1;
          end
          DATA: begin
            wdata <= {wdata[23:0], rx_data};
            cnt <= cnt + 2'd1;
          end
          default: ;
        endcase
      if (state == BUS_WR && state_n == TX_LOAD) begin
        reply <= {8'h4B, 24'h0};
        cnt <= '0;
      end
      if (state == BUS_RD && state_n == TX_LOAD) begin
        reply <= bus_rdata;
        cnt <= 2'd3;
      end
      if (state == TX_WAIT && state_n == TX_LOAD) begin
        reply <= reply << 8;
        cnt <= cnt - 2'd1;
      end
    end
  assign rx_ack = !reset && (err || take);
  assign tx_data = reply[31:24];
  assign tx_wr = !reset && state == TX_LOAD && !tx_busy;
  assign bus_addr = addr & ~32'h3;
  assign bus_wdata = wdata;
  assign bus_wmask = (state == BUS_WR && first) ? 4'hF : 4'h0;
  assign bus_rstrb = state == BUS_RD && first;
  assign active = state != IDLE;
endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge: directed checks of the bridge with simple uart and bus responder models.
module tb_uart_bus_bridge;
  logic clk = 0, reset = 1;
  logic [7:0] rx_data = 0;
  logic rx_avail = 0, rx_error = 0, rx_ack;
  logic [7:0] tx_data;
  logic tx_wr, tx_busy = 0;
  logic [31:0] bus_addr, bus_wdata, bus_rdata = 32'h12345678;
  logic [3:0] bus_wmask;
  logic bus_rstrb, bus_rbusy = 0, bus_wbusy = 0, active;
  int n_run = 0, n_fail = 0;
  int wm_cnt = 0, rs_cnt = 0, ack_cnt = 0, busy_left = 0, rd_left = 0, wr_left = 0;
  logic [31:0] waddr = 0, wdat = 0, raddr = 0;
  logic [7:0] tx_q[$];
  int w0, r0, t0, a0;

  uart_bus_bridge #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_avail(rx_avail), .rx_error(rx_error),
    .rx_ack(rx_ack), .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask), .bus_rstrb(bus_rstrb),
    .bus_rdata(bus_rdata), .bus_rbusy(bus_rbusy), .bus_wbusy(bus_wbusy), .active(active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_wmask != 4'h0) begin
      wm_cnt++;
      waddr = bus_addr;
      wdat = bus_wdata;
      wr_left = 2;
    end else if (wr_left > 0) wr_left--;
    if (bus_rstrb) begin
      rs_cnt++;
      raddr = bus_addr;
      rd_left = 3;
    end else if (rd_left > 0) rd_left--;
    if (tx_wr) begin
      tx_q.push_back(tx_data);
      busy_left = 4;
    end else if (busy_left > 0) busy_left--;
    if (rx_ack) ack_cnt++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    tx_busy = busy_left != 0;
    bus_rbusy = rd_left != 0;
    bus_wbusy = wr_left != 0;
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    @(posedge clk);
    #1;
    rx_data = b;
    rx_avail = 1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rx_ack && t < 300);
    check("rx_ack", 32'(rx_ack), 32'd1);
    @(posedge clk);
    #1;
    rx_avail = 0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((active || busy_left != 0) && t < 500);
    check(tag, 32'(active), 32'd0);
  endtask

  task automatic snap();
    w0 = wm_cnt;
    r0 = rs_cnt;
    t0 = tx_q.size();
    a0 = ack_cnt;
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    check("rst_active", 32'(active), 32'd0);
    check("rst_tx_wr", 32'(tx_wr), 32'd0);
    check("rst_rx_ack", 32'(rx_ack), 32'd0);
    check("rst_wmask", 32'(bus_wmask), 32'd0);
    check("rst_rstrb", 32'(bus_rstrb), 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);

    snap();
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10); send_byte(8'h04);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    wait_idle("w_idle");
    check("w_pulses", 32'(wm_cnt - w0), 32'd1);
    check("w_addr", waddr, 32'h00001004);
    check("w_data", wdat, 32'hDEADBEEF);
    check("w_rstrb", 32'(rs_cnt - r0), 32'd0);
    check("w_tx_len", 32'(tx_q.size() - t0), 32'd1);
    if (tx_q.size() > t0) check("w_tx0", 32'(tx_q[t0]), 32'h4B);
    check("w_acks", 32'(ack_cnt - a0), 32'd9);

    snap();
    bus_rdata = 32'h12345678;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10); send_byte(8'h04);
    wait_idle("r_idle");
    check("r_rstrb", 32'(rs_cnt - r0), 32'd1);
    check("r_addr", raddr, 32'h00001004);
    check("r_wmask", 32'(wm_cnt - w0), 32'd0);
    check("r_tx_len", 32'(tx_q.size() - t0), 32'd4);
    if (tx_q.size() >= t0 + 4) begin
      check("r_tx0", 32'(tx_q[t0]), 32'h12);
      check("r_tx1", 32'(tx_q[t0+1]), 32'h34);
      check("r_tx2", 32'(tx_q[t0+2]), 32'h56);
      check("r_tx3", 32'(tx_q[t0+3]), 32'h78);
    end

    snap();
    send_byte(8'h00);
    wait_idle("q_idle");
    send_byte(8'h50);
    wait_idle("p_idle");
    check("qp_tx_len", 32'(tx_q.size() - t0), 32'd2);
    if (tx_q.size() >= t0 + 2) begin
      check("q_tx", 32'(tx_q[t0]), 32'h3F);
      check("p_tx", 32'(tx_q[t0+1]), 32'h4B);
    end
    check("qp_bus", 32'((wm_cnt - w0) + (rs_cnt - r0)), 32'd0);

    snap();
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
    repeat (50) @(negedge clk);
    check("to_still_active", 32'(active), 32'd1);
    repeat (70) @(negedge clk);
    check("to_idle", 32'(active), 32'd0);
    check("to_no_tx", 32'(tx_q.size() - t0), 32'd0);
    check("to_no_bus", 32'(wm_cnt - w0), 32'd0);
    send_byte(8'h50);
    wait_idle("to_p_idle");
    check("to_p_len", 32'(tx_q.size() - t0), 32'd1);
    if (tx_q.size() > t0) check("to_p_tx", 32'(tx_q[t0]), 32'h4B);

    snap();
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
    @(posedge clk);
    #1;
    rx_error = 1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rx_ack && t < 300);
    check("err_ack", 32'(rx_ack), 32'd1);
    @(posedge clk);
    #1;
    rx_error = 0;
    repeat (5) @(negedge clk);
    check("err_idle", 32'(active), 32'd0);
    check("err_no_bus", 32'(rs_cnt - r0), 32'd0);
    check("err_no_tx", 32'(tx_q.size() - t0), 32'd0);
    bus_rdata = 32'hA5C30F1E;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10); send_byte(8'h07);
    wait_idle("err_r_idle");
    check("err_r_rstrb", 32'(rs_cnt - r0), 32'd1);
    check("unaligned_addr", raddr, 32'h00001004);
    check("err_r_len", 32'(tx_q.size() - t0), 32'd4);
    if (tx_q.size() >= t0 + 4)
      check("err_r_data", {tx_q[t0], tx_q[t0+1], tx_q[t0+2], tx_q[t0+3]}, 32'hA5C30F1E);

    snap();
    bus_rdata = 32'h12345678;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20); send_byte(8'h00);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (tx_q.size() == t0 && t < 500);
    check("rst_tx_started", 32'(tx_q.size() - t0), 32'd1);
    @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    check("mid_rst_active", 32'(active), 32'd0);
    check("mid_rst_tx_wr", 32'(tx_wr), 32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check("mid_rst_addr", bus_addr, 32'd0);
    check("mid_rst_wdata", bus_wdata, 32'd0);
    repeat (40) @(negedge clk);
    check("mid_rst_no_more_tx", 32'(tx_q.size() - t0), 32'd1);
    check("mid_rst_idle", 32'(active), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
